// File: rtl/ntt_ctrl_pkg.sv
// Shared types and index math for the NTT sequencer: FSM encoding, drain depth,
// and the Cooley-Tukey butterfly address / twiddle formulas.
package ntt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_e;

    function automatic int unsigned drain_depth(int unsigned mem_lat, int unsigned bfu_lat);
        return mem_lat + bfu_lat;
    endfunction

    function automatic int unsigned stage_width(int unsigned logn);
        return (logn > 1) ? $clog2(logn) : 1;
    endfunction

    function automatic int unsigned bf_addr_x(int unsigned k, int unsigned stg);
        int unsigned j;
        int unsigned g;
        j = k & ((32'd1 << stg) - 32'd1);
        g = k >> stg;
        return (g << (stg + 32'd1)) | j;
    endfunction

    function automatic int unsigned bf_addr_y(int unsigned k, int unsigned stg);
        return bf_addr_x(k, stg) + (32'd1 << stg);
    endfunction

    function automatic int unsigned bf_tw(int unsigned k, int unsigned stg, int unsigned logn);
        return (k & ((32'd1 << stg) - 32'd1)) << (logn - 32'd1 - stg);
    endfunction

endpackage

// File: rtl/ntt_ctrl_if.sv
// Handshake / address bundle between the NTT sequencer and its memory + butterfly.
// The hold input exists only when NTT_CTRL_HOLD_EN is defined.
interface ntt_ctrl_if import ntt_ctrl_pkg::*; #(
    parameter int LOGN = 8
) ();
    localparam int SW = int'(stage_width(LOGN));

    logic            start;
`ifdef NTT_CTRL_HOLD_EN
    logic            hold;
`endif
    logic [LOGN-1:0] rd_addr_x;
    logic [LOGN-1:0] rd_addr_y;
    logic [LOGN-2:0] tw_idx;
    logic            rd_en;
    logic            bfu_en;
    logic            wr_en;
    logic [LOGN-1:0] wr_addr_x;
    logic [LOGN-1:0] wr_addr_y;
    logic [SW-1:0]   stage;
    logic            busy;
    logic            done;

`ifdef NTT_CTRL_HOLD_EN
    modport master (
        input  start, hold,
        output rd_addr_x, rd_addr_y, tw_idx, rd_en, bfu_en, wr_en,
        output wr_addr_x, wr_addr_y, stage, busy, done
    );
    modport slave (
        output start, hold,
        input  rd_addr_x, rd_addr_y, tw_idx, rd_en, bfu_en, wr_en,
        input  wr_addr_x, wr_addr_y, stage, busy, done
    );
`else
    modport master (
        input  start,
        output rd_addr_x, rd_addr_y, tw_idx, rd_en, bfu_en, wr_en,
        output wr_addr_x, wr_addr_y, stage, busy, done
    );
    modport slave (
        output start,
        input  rd_addr_x, rd_addr_y, tw_idx, rd_en, bfu_en, wr_en,
        input  wr_addr_x, wr_addr_y, stage, busy, done
    );
`endif

endinterface

// File: rtl/ntt_issue_delay.sv
// Valid + payload shift register of depth DEPTH with synchronous active-low clear.
// Exposes the valid bit at tap TAP and the full record at the last stage.
module ntt_issue_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    parameter int TAP   = 1
) (
    input  logic         clk_i,
    input  logic         clr_ni,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         tap_valid_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0][W-1:0] data_q, data_d;

    always_comb begin
        valid_d    = '0;
        data_d     = '0;
        valid_d[0] = valid_i;
        data_d[0]  = data_i;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign tap_valid_o = valid_q[TAP-1];
    assign valid_o     = valid_q[DEPTH-1];
    assign data_o      = data_q[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// In-place radix-2 NTT sequencer: issues one butterfly per RUN cycle, drains the
// read/write pipeline between stages. Optional issue stall via NTT_CTRL_HOLD_EN. MEM_LAT >= 1.
module ntt_ctrl import ntt_ctrl_pkg::*; #(
    parameter int N       = 256,
    parameter int LOGN    = 8,
    parameter int MEM_LAT = 1,
    parameter int BFU_LAT = 1
) (
    input  logic      clk_i,
    input  logic      reset_ni,
    ntt_ctrl_if.master bus
);
    localparam int D  = int'(drain_depth(MEM_LAT, BFU_LAT));
    localparam int KW = LOGN - 1;
    localparam int SW = int'(stage_width(LOGN));
    localparam int CW = $clog2(D) + 1;

    localparam logic [KW-1:0] K_LAST     = KW'(N / 2 - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(LOGN - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(D - 1);

    ntt_state_e      state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            hold_w;
    logic            issue_w;
    logic [LOGN-1:0] rd_x_w, rd_y_w;
    logic [LOGN-2:0] rd_tw_w;
    logic [2*LOGN-1:0] wr_data_w;

`ifdef NTT_CTRL_HOLD_EN
    assign hold_w = bus.hold;
`else
    assign hold_w = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        issue_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                    stage_d = '0;
                end
            end
            ST_RUN: begin
                if (!hold_w) begin
                    issue_w = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Down-counter: the stage ends once the last write of this stage has landed.
                if (cnt_q == '0) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        stage_d = stage_q + SW'(1);
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                stage_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Addresses are forced to zero when nothing issues so bubbles carry a clean payload.
    always_comb begin
        rd_x_w  = '0;
        rd_y_w  = '0;
        rd_tw_w = '0;
        if (issue_w) begin
            rd_x_w  = LOGN'(bf_addr_x(32'(k_q), 32'(stage_q)));
            rd_y_w  = LOGN'(bf_addr_y(32'(k_q), 32'(stage_q)));
            rd_tw_w = (LOGN-1)'(bf_tw(32'(k_q), 32'(stage_q), LOGN));
        end
    end

    ntt_issue_delay #(
        .DEPTH (D),
        .W     (2 * LOGN),
        .TAP   (MEM_LAT)
    ) u_issue_delay (
        .clk_i       (clk_i),
        .clr_ni      (reset_ni),
        .valid_i     (issue_w),
        .data_i      ({rd_x_w, rd_y_w}),
        .tap_valid_o (bus.bfu_en),
        .valid_o     (bus.wr_en),
        .data_o      (wr_data_w)
    );

    assign bus.rd_en     = issue_w;
    assign bus.rd_addr_x = rd_x_w;
    assign bus.rd_addr_y = rd_y_w;
    assign bus.tw_idx    = rd_tw_w;
    assign bus.wr_addr_x = wr_data_w[2*LOGN-1:LOGN];
    assign bus.wr_addr_y = wr_data_w[LOGN-1:0];
    assign bus.stage     = stage_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl with N=8, LOGN=3, MEM_LAT=BFU_LAT=1, including a
// behavioural coefficient memory + butterfly (p=7681) checked against a direct DFT.
module tb_ntt_ctrl;
    localparam int P = 7681;

    logic clk;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    ntt_ctrl_if #(.LOGN(3)) bus ();

    ntt_ctrl #(.N(8), .LOGN(3), .MEM_LAT(1), .BFU_LAT(1)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] exp_x  [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0] exp_y  [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [1:0] exp_tw [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

    // Behavioural memory and butterfly
    int   mem      [8];
    int   load_img [8];
    int   tw_rom   [4];
    logic mem_load = 1'b0;
    int   rdx, rdy, rdw, bx, by;

    always @(posedge clk) begin
        if (mem_load)
            for (int i = 0; i < 8; i++) mem[i] <= load_img[i];
        if (bus.rd_en) begin
            rdx <= mem[bus.rd_addr_x];
            rdy <= mem[bus.rd_addr_y];
            rdw <= tw_rom[bus.tw_idx];
        end
        if (bus.bfu_en) begin
            bx <= (rdx + (rdw * rdy) % P) % P;
            by <= (rdx + P - (rdw * rdy) % P) % P;
        end
        if (bus.wr_en) begin
            mem[bus.wr_addr_x] <= bx;
            mem[bus.wr_addr_y] <= by;
        end
    end

    function automatic longint powmod(longint b, int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % P;
        return r;
    endfunction

    function automatic int bitrev3(int i);
        logic [2:0] v;
        v = i[2:0];
        return int'({v[0], v[1], v[2]});
    endfunction

    task automatic reset_dut();
        reset_n   = 1'b0;
        bus.start = 1'b0;
`ifdef NTT_CTRL_HOLD_EN
        bus.hold  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++;
        if ({bus.rd_en, bus.bfu_en, bus.wr_en, bus.done} !== 4'b0) begin
            bad++; $display("FAIL reset_strobes got=%b want=0000", {bus.rd_en, bus.bfu_en, bus.wr_en, bus.done});
        end
        total++;
        if ({bus.rd_addr_x, bus.rd_addr_y, bus.tw_idx, bus.wr_addr_x, bus.wr_addr_y, bus.stage} !== '0) begin
            bad++; $display("FAIL reset_addrs got=%h want=0",
                {bus.rd_addr_x, bus.rd_addr_y, bus.tw_idx, bus.wr_addr_x, bus.wr_addr_y, bus.stage});
        end
    endtask

    task automatic test_single();
        logic       h_rd [64];
        logic [2:0] h_x  [64];
        logic [2:0] h_y  [64];
        logic       e_rd, e_bfu, e_wr, e_done, e_busy;
        logic [1:0] e_stage;
        int         idx, wr_cnt;
        wr_cnt = 0;
        for (int i = 0; i < 64; i++) begin h_rd[i] = 1'b0; h_x[i] = '0; h_y[i] = '0; end
        reset_dut();
        @(posedge clk); #1 bus.start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk); #1 bus.start = 1'b0;
            @(negedge clk);
            e_rd = (c <= 18) && (((c - 1) % 6) < 4);
            h_rd[c] = e_rd;
            total++;
            if (bus.rd_en !== e_rd) begin bad++; $display("FAIL single_rd_en c=%0d got=%b want=%b", c, bus.rd_en, e_rd); end
            if (e_rd) begin
                idx = ((c - 1) / 6) * 4 + (c - 1) % 6;
                h_x[c] = exp_x[idx];
                h_y[c] = exp_y[idx];
                total++;
                if ({bus.rd_addr_x, bus.rd_addr_y, bus.tw_idx} !== {exp_x[idx], exp_y[idx], exp_tw[idx]}) begin
                    bad++; $display("FAIL single_addr c=%0d got x=%0d y=%0d tw=%0d want x=%0d y=%0d tw=%0d", c,
                        bus.rd_addr_x, bus.rd_addr_y, bus.tw_idx, exp_x[idx], exp_y[idx], exp_tw[idx]);
                end
            end
            e_bfu = h_rd[c-1];
            total++;
            if (bus.bfu_en !== e_bfu) begin bad++; $display("FAIL single_bfu_en c=%0d got=%b want=%b", c, bus.bfu_en, e_bfu); end
            e_wr = (c >= 2) ? h_rd[c-2] : 1'b0;
            total++;
            if (bus.wr_en !== e_wr) begin bad++; $display("FAIL single_wr_en c=%0d got=%b want=%b", c, bus.wr_en, e_wr); end
            if (bus.wr_en === 1'b1) begin
                wr_cnt++;
                if (e_wr) begin
                    total++;
                    if ({bus.wr_addr_x, bus.wr_addr_y} !== {h_x[c-2], h_y[c-2]}) begin
                        bad++; $display("FAIL single_wr_addr c=%0d got x=%0d y=%0d want x=%0d y=%0d", c,
                            bus.wr_addr_x, bus.wr_addr_y, h_x[c-2], h_y[c-2]);
                    end
                end
            end
            e_done = (c == 19);
            total++;
            if (bus.done !== e_done) begin bad++; $display("FAIL single_done c=%0d got=%b want=%b", c, bus.done, e_done); end
            e_busy = (c <= 19);
            total++;
            if (bus.busy !== e_busy) begin bad++; $display("FAIL single_busy c=%0d got=%b want=%b", c, bus.busy, e_busy); end
            if (c <= 19) begin
                e_stage = (c <= 6) ? 2'd0 : (c <= 12) ? 2'd1 : 2'd2;
                total++;
                if (bus.stage !== e_stage) begin bad++; $display("FAIL single_stage c=%0d got=%0d want=%0d", c, bus.stage, e_stage); end
            end
        end
        total++;
        if (wr_cnt != 12) begin bad++; $display("FAIL single_wr_count got=%0d want=12", wr_cnt); end
    endtask

    task automatic test_back_to_back();
        logic e_done, e_busy;
        int   rd_cnt;
        rd_cnt = 0;
        reset_dut();
        @(posedge clk); #1 bus.start = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1 bus.start = (c <= 38);
            @(negedge clk);
            if (c <= 19 && bus.rd_en === 1'b1) rd_cnt++;
            e_done = (c == 19) || (c == 39);
            total++;
            if (bus.done !== e_done) begin bad++; $display("FAIL b2b_done c=%0d got=%b want=%b", c, bus.done, e_done); end
            e_busy = (c <= 19) || (c >= 21 && c <= 39);
            total++;
            if (bus.busy !== e_busy) begin bad++; $display("FAIL b2b_busy c=%0d got=%b want=%b", c, bus.busy, e_busy); end
            if (c == 21) begin
                total++;
                if ({bus.rd_en, bus.rd_addr_x, bus.rd_addr_y} !== {1'b1, 3'd0, 3'd1}) begin
                    bad++; $display("FAIL b2b_restart got en=%b x=%0d y=%0d want en=1 x=0 y=1",
                        bus.rd_en, bus.rd_addr_x, bus.rd_addr_y);
                end
            end
        end
        total++;
        if (rd_cnt != 12) begin bad++; $display("FAIL b2b_first_reads got=%0d want=12", rd_cnt); end
    endtask

    task automatic test_abort();
        reset_dut();
        @(posedge clk); #1 bus.start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1 bus.start = 1'b0; reset_n = (c != 7);
            @(negedge clk);
            if (c == 7) begin
                total++;
                if ({bus.rd_en, bus.rd_addr_x, bus.rd_addr_y} !== {1'b1, 3'd0, 3'd2}) begin
                    bad++; $display("FAIL abort_pre got en=%b x=%0d y=%0d want en=1 x=0 y=2",
                        bus.rd_en, bus.rd_addr_x, bus.rd_addr_y);
                end
            end
            if (c == 8) begin
                total++;
                if ({bus.rd_en, bus.bfu_en, bus.wr_en, bus.busy, bus.done, bus.rd_addr_x, bus.rd_addr_y,
                     bus.tw_idx, bus.wr_addr_x, bus.wr_addr_y, bus.stage} !== '0) begin
                    bad++; $display("FAIL abort_outputs got busy=%b wr=%b bfu=%b stage=%0d want all zero",
                        bus.busy, bus.wr_en, bus.bfu_en, bus.stage);
                end
            end
            if (c >= 8) begin
                total++;
                if ({bus.wr_en, bus.busy} !== 2'b00) begin
                    bad++; $display("FAIL abort_quiet c=%0d got wr=%b busy=%b want 0 0", c, bus.wr_en, bus.busy);
                end
            end
        end
    endtask

`ifdef NTT_CTRL_HOLD_EN
    task automatic test_hold();
        logic e_rd;
        int   cp, wr_cnt;
        wr_cnt = 0;
        reset_dut();
        @(posedge clk); #1 bus.start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1 bus.start = 1'b0; bus.hold = (c >= 2 && c <= 4);
            @(negedge clk);
            cp = (c >= 5) ? c - 3 : c;
            e_rd = (c < 2 || c > 4) && (cp <= 18) && (((cp - 1) % 6) < 4);
            total++;
            if (bus.rd_en !== e_rd) begin bad++; $display("FAIL hold_rd_en c=%0d got=%b want=%b", c, bus.rd_en, e_rd); end
            if (bus.wr_en === 1'b1) wr_cnt++;
            if (c == 3) begin
                total++;
                if ({bus.wr_en, bus.wr_addr_x, bus.wr_addr_y} !== {1'b1, 3'd0, 3'd1}) begin
                    bad++; $display("FAIL hold_inflight got en=%b x=%0d y=%0d want en=1 x=0 y=1",
                        bus.wr_en, bus.wr_addr_x, bus.wr_addr_y);
                end
            end
            if (c == 5) begin
                total++;
                if ({bus.rd_addr_x, bus.rd_addr_y} !== {3'd2, 3'd3}) begin
                    bad++; $display("FAIL hold_resume got x=%0d y=%0d want x=2 y=3", bus.rd_addr_x, bus.rd_addr_y);
                end
            end
            total++;
            if (bus.done !== (c == 22)) begin bad++; $display("FAIL hold_done c=%0d got=%b want=%b", c, bus.done, (c == 22)); end
        end
        bus.hold = 1'b0;
        total++;
        if (wr_cnt != 12) begin bad++; $display("FAIL hold_wr_count got=%0d want=12", wr_cnt); end
    endtask
`endif

    task automatic test_ntt_e2e();
        int     a    [8];
        longint expv [8];
        longint w;
        logic   saw_done;
        w = 0;
        for (int c = 2; c < P && w == 0; c++)
            if (powmod(c, 4) == P - 1) w = c;
        for (int i = 0; i < 4; i++) tw_rom[i] = int'(powmod(w, i));
        for (int n = 0; n < 8; n++) a[n] = n + 1;
        for (int i = 0; i < 8; i++) load_img[i] = a[bitrev3(i)];
        for (int i = 0; i < 8; i++) begin
            expv[i] = 0;
            for (int n = 0; n < 8; n++) expv[i] = (expv[i] + a[n] * powmod(w, (n * i) % 8)) % P;
        end
        reset_dut();
        @(posedge clk); #1 mem_load = 1'b1;
        @(posedge clk); #1 mem_load = 1'b0; bus.start = 1'b1;
        saw_done = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1 bus.start = 1'b0;
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b1) begin bad++; $display("FAIL e2e_done got=%b want=1", saw_done); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (longint'(mem[i]) != expv[i]) begin
                bad++; $display("FAIL e2e_coef[%0d] got=%0d want=%0d", i, mem[i], expv[i]);
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b0;
`ifdef NTT_CTRL_HOLD_EN
        bus.hold  = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
`ifdef NTT_CTRL_HOLD_EN
        test_hold();
`endif
        test_ntt_e2e();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
